// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DELIV = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Multicycle fetch sequencer: owns the PC, runs a single-outstanding imem
// handshake and hands one instruction at a time to decode.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] pc
);
    import fetch_pkg::*;

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  instr_pc_q, instr_pc_d;
    logic         kill_q, kill_d;
    logic         instr_valid_q, instr_valid_d;
    logic [31:0]  redir_pc;

    assign redir_pc = word_align(redirect_pc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            fetch_pc_q    <= RESET_PC;
            instr_q       <= NOP_INSTR;
            instr_pc_q    <= RESET_PC;
            kill_q        <= 1'b0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_pc_q    <= fetch_pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            kill_q        <= kill_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fetch_pc_d    = fetch_pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        kill_d        = kill_q;
        instr_valid_d = instr_valid_q;

        unique case (state_q)
            IDLE: begin
                if (redirect_valid) pc_d = redir_pc;
                state_d = REQ;
            end
            REQ: begin
                if (redirect_valid) pc_d = redir_pc;
                if (imem_req_ready) begin
                    // Accepted request is in flight even if a redirect lands now;
                    // kill marks its response for discard.
                    fetch_pc_d = pc_q;
                    kill_d     = redirect_valid;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    if (kill_q || redirect_valid) begin
                        kill_d = 1'b0;
                        if (redirect_valid) pc_d = redir_pc;
                        state_d = REQ;
                    end else begin
                        instr_d       = imem_rsp_data;
                        instr_pc_d    = fetch_pc_q;
                        instr_valid_d = 1'b1;
                        pc_d          = fetch_pc_q + PC_STEP;
                        state_d       = DELIV;
                    end
                end else if (redirect_valid) begin
                    kill_d = 1'b1;
                    pc_d   = redir_pc;
                end
            end
            DELIV: begin
                if (redirect_valid || !stall) begin
                    if (redirect_valid) pc_d = redir_pc;
                    instr_valid_d = 1'b0;
                    instr_d       = NOP_INSTR;
                    state_d       = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign imem_req_valid = (state_q == REQ);
    assign imem_req_addr  = pc_q;
    assign instr_valid    = instr_valid_q;
    assign instr          = instr_q;
    assign instr_pc       = instr_pc_q;
    assign pc             = pc_q;

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Multicycle instruction-fetch sequencer. Owns the architectural PC and drives a single-outstanding request/response handshake to instruction memory.
- Delivers one instruction at a time to decode, honouring decode back-pressure.
- Applies redirects (taken branch, jal, jalr target, already resolved by execute) at any point in the fetch, discarding stale responses.
- Sits between the instruction memory port and the decode stage.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, value driven on instr while instr_valid=0 (addi x0,x0,0)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
redirect_valid  in  1  execute resolved a taken branch/jal/jalr this cycle
redirect_pc  in  32  target PC; bits [1:0] forced to 0 internally
stall  in  1  decode cannot accept instr this cycle
imem_req_valid  out  1  fetch request valid
imem_req_addr  out  32  fetch address (= pc)
imem_req_ready  in  1  memory accepts request this cycle
imem_rsp_valid  in  1  response data valid
imem_rsp_data  in  32  fetched instruction word
instr_valid  out  1  instr/instr_pc valid for decode
instr  out  32  delivered instruction
instr_pc  out  32  PC of delivered instruction
pc  out  32  current architectural fetch PC

Behaviour:
- Reset (async, asserted): state=IDLE, pc=RESET_PC, fetch_pc=RESET_PC, kill=0, instr_valid=0, instr=NOP_INSTR, instr_pc=RESET_PC, imem_req_valid=0. Reset asserted mid-fetch abandons the transaction; responses arriving after deassertion are ignored until a new request is accepted.
- All outputs are registered or decoded from registered state only; there is no input-to-output combinational path.
- States: IDLE, REQ, WAIT, DELIV.
- IDLE: request deasserted; go to REQ on the next cycle unconditionally.
- REQ: imem_req_valid=1, imem_req_addr=pc.
  - On imem_req_ready: fetch_pc<=pc; go to WAIT.
  - If redirect_valid coincides with the handshake: request is still consumed; kill<=1, pc<=redirect_pc, go to WAIT.
  - If redirect_valid without ready: pc<=redirect_pc; stay in REQ. Address changes next cycle; the request is not sticky until accepted.
- WAIT: imem_req_valid=0.
  - redirect_valid without imem_rsp_valid: kill<=1, pc<=redirect_pc; stay in WAIT.
  - imem_rsp_valid with kill=1 or redirect_valid: discard data, kill<=0, pc<=redirect_pc if redirect_valid else unchanged; go to REQ.
  - imem_rsp_valid, clean: instr<=imem_rsp_data, instr_pc<=fetch_pc, instr_valid<=1, pc<=fetch_pc+4 (mod 2^32, wraps 32'hFFFF_FFFC to 0); go to DELIV.
- DELIV: instr_valid=1.
  - redirect_valid: instr_valid<=0, instr<=NOP_INSTR, pc<=redirect_pc; go to REQ. Redirect has priority over stall.
  - Else !stall: instruction consumed this cycle; instr_valid<=0, instr<=NOP_INSTR; go to REQ.
  - Else: hold instr, instr_pc, instr_valid unchanged.
- Latency: minimum 3 cycles per instruction (REQ accepted → rsp next cycle → DELIV). First imem_req_valid appears 1 cycle after reset deassertion.
- Successive redirects: the last one before the next accepted request wins.
- imem_rsp_valid outside WAIT is ignored (bench asserts it never occurs).

Decomposition:
- fetch_pkg holds fetch_state_e (IDLE, REQ, WAIT, DELIV), NOP_INSTR, PC_STEP=32'd4 and a word-align helper function.
- Single module, no sub-module: the next-PC mux and FSM are tightly coupled.

Test Plan:
- Reset release, ready=1, rsp 1 cycle later with 32'h0010_0093 → imem_req_addr=0 at cycle 1; instr_valid at cycle 3 with instr=32'h0010_0093, instr_pc=0; next request addr=4.
- stall held 3 cycles in DELIV → instr/instr_pc stable for all 3 cycles; next request only after stall drops; pc=fetch_pc+4.
- redirect_pc=32'h0000_0100 while in WAIT, then rsp_valid → response discarded, no instr_valid; next request addr=0x100.
- redirect in DELIV with stall=1 → instr_valid drops next cycle; next request addr=redirect_pc.
- imem_req_ready low 4 cycles, redirect to 0x200 on cycle 2 → addr switches to 0x200; only 0x200 is accepted and delivered.
- pc=32'hFFFF_FFFC fetched cleanly → next request addr=0; redirect_pc=32'h0000_0103 → request addr 0x100.
